// File: rtl/mem_arbiter_pkg.sv
// mem_pkg: shared constants for the main-memory arbiter slice.
//   LINE_W / ADDR_W  line and byte-address widths; LINE_W matches the
//                    main-memory data-width define.
//   S_*              arbiter FSM state encoding.
//   OWN_*            transaction owner encoding (I-cache / D-cache).
package mem_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with an update-on-grant pointer.
//   clk, reset   clock, synchronous active-high reset
//   en           grant allowed this cycle
//   req_i/req_d  requests from the I and D sides
//   grant        a grant is issued this cycle
//   owner        granted side (OWN_I / OWN_D), valid when grant is high
//   rr           side preferred on a tie (reset: OWN_D)
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic grant,
  output logic owner,
  output logic rr
);

  always_comb begin
    grant = en & (req_i | req_d);
    if (req_i & req_d) owner = rr;
    else if (req_d)    owner = OWN_D;
    else               owner = OWN_I;
  end

  // Whether the grant came from a tie or a lone request, the pointer
  // always moves to the side that was not served.
  always_ff @(posedge clk) begin
    if (reset)      rr <= OWN_D;
    else if (grant) rr <= ~owner;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache
// line-fill path and the D-cache fill/writeback path, one full-line
// transaction at a time, and adds a fixed MEM_LAT-cycle access latency.
//
// Handshake: a requester raises req (with stable addr/we/wdata) and holds
// it until its one-cycle done pulse; it drops req in the cycle after done.
// A req still high when the FSM returns to IDLE is a new request.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req, i_addr              I-side line read request
//   d_req, d_we, d_addr, d_wdata  D-side line read / writeback request
//   i_done, d_done             one-cycle completion pulses
//   rdata                      registered read line, shared by both sides
//   busy                       high in BUSY and DONE
//   mem_addr/mem_wdata/mem_we  drive to main memory
//   mem_rdata                  combinational read data from main memory
//   state                      FSM state (debug)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int LINE_W  = mem_pkg::LINE_W,
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int MEM_LAT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              i_done,
  output logic              d_done,
  output logic [LINE_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        state
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [LINE_W-1:0] own_wdata;

  logic grant;
  logic gnt_owner;
  logic rr;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_IDLE),
    .req_i (i_req),
    .req_d (d_req),
    .grant (grant),
    .owner (gnt_owner),
    .rr    (rr)
  );

  wire last_cycle = (state == S_BUSY) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      owner     <= OWN_I;
      own_we    <= 1'b0;
      own_addr  <= '0;
      own_wdata <= '0;
      rdata     <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner <= gnt_owner;
            cnt   <= '0;
            state <= S_BUSY;
            if (gnt_owner == OWN_D) begin
              own_we    <= d_we;
              own_addr  <= d_addr;
              own_wdata <= d_wdata;
            end else begin
              // I-side fills are always reads; the write line is unused.
              own_we   <= 1'b0;
              own_addr <= i_addr;
            end
          end
        end
        S_BUSY: begin
          if (last_cycle) begin
            // Counter parks at zero so it never passes MEM_LAT-1.
            cnt <= '0;
            if (!own_we) rdata <= mem_rdata;
            i_done <= (owner == OWN_I);
            d_done <= (owner == OWN_D);
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_BUSY) || (state == S_DONE);
  // Address comes straight from the latched owner address, so it holds
  // steady through DONE and IDLE.
  assign mem_addr  = {own_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata = own_wdata;
  // Gated by reset so an abort on the strobe cycle never writes memory.
  assign mem_we    = last_cycle & own_we & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT (MEM_LAT = 5) ----------------
  logic         i_req, d_req, d_we;
  logic [31:0]  i_addr, d_addr;
  logic [127:0] d_wdata;
  logic         i_done, d_done, busy, mem_we;
  logic [127:0] rdata, mem_wdata, mem_rdata;
  logic [31:0]  mem_addr;
  logic [1:0]   state;

  mem_arbiter #(.MEM_LAT(5)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_done(i_done), .d_done(d_done), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .state(state)
  );

  // Memory model: unwritten lines return a fixed address pattern.
  logic [127:0] wr_mem [4096];
  logic [4095:0] wr_vld;
  logic mem_clear;
  wire [11:0] idx = mem_addr[15:4];
  assign mem_rdata = wr_vld[idx] ? wr_mem[idx]
                                 : {4{32'hC0DE_0000 | {20'h0, idx}}};
  always @(posedge clk) begin
    if (mem_clear) wr_vld <= '0;
    else if (mem_we) begin
      wr_vld[idx] <= 1'b1;
      wr_mem[idx] <= mem_wdata;
    end
  end

  // ---------------- DUT2 (MEM_LAT = 1) ----------------
  logic         i_req2, d_req2, d_we2;
  logic [31:0]  i_addr2, d_addr2;
  logic [127:0] d_wdata2;
  logic         i_done2, d_done2, busy2, mem_we2;
  logic [127:0] rdata2, mem_wdata2, mem_rdata2;
  logic [31:0]  mem_addr2;
  logic [1:0]   state2;

  mem_arbiter #(.MEM_LAT(1)) dut2 (
    .clk(clk), .reset(reset),
    .i_req(i_req2), .i_addr(i_addr2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .i_done(i_done2), .d_done(d_done2), .rdata(rdata2), .busy(busy2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
    .mem_rdata(mem_rdata2), .state(state2)
  );
  assign mem_rdata2 = {4{32'hC0DE_0000 | {20'h0, mem_addr2[15:4]}}};

  // ---------------- expected values (hand-computed) ----------------
  localparam logic [127:0] LINE_100  = 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010;
  localparam logic [127:0] LINE_3010 = 128'hC0DE0301_C0DE0301_C0DE0301_C0DE0301;
  localparam logic [127:0] LINE_3000 = 128'hC0DE0300_C0DE0300_C0DE0300_C0DE0300;
  localparam logic [127:0] LINE_40   = 128'hC0DE0004_C0DE0004_C0DE0004_C0DE0004;
  localparam logic [127:0] WLINE     = 128'hDEAD0000_11112222_33334444_0000BEEF;
  localparam logic [127:0] WLINE2    = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observe DUT from a grant cycle until the first done pulse (bounded).
  int          w_n, w_i_cnt, w_d_cnt, w_we_cnt, w_we_cyc;
  logic [31:0] w_we_addr, w_addr1;
  logic        w_busy1;

  task automatic watch();
    w_n = 0; w_i_cnt = 0; w_d_cnt = 0; w_we_cnt = 0; w_we_cyc = 0;
    w_we_addr = '0; w_addr1 = '0; w_busy1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) begin
        w_addr1 = mem_addr;
        w_busy1 = busy;
      end
      if (mem_we) begin
        w_we_cnt++;
        w_we_cyc  = n;
        w_we_addr = mem_addr;
      end
      if (i_done) w_i_cnt++;
      if (d_done) w_d_cnt++;
      if (i_done || d_done) begin
        w_n = n;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int extra_done;
    reset = 1'b1; mem_clear = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req2 = 0; i_addr2 = '0; d_req2 = 0; d_we2 = 0; d_addr2 = '0; d_wdata2 = '0;
    step(); step();
    reset = 1'b0; mem_clear = 1'b0;

    // Reset state
    chk("rst_state", 128'(state), 128'(ST_IDLE));
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rdata", rdata, 128'd0);
    chk("rst_done", 128'({i_done, d_done}), 128'd0);
    chk("rst_mem_we", 128'(mem_we), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);

    // 1: I read, unaligned address
    i_req = 1; i_addr = 32'h0000_0104;
    watch();
    chk("t1_addr", 128'(w_addr1), 128'h100);
    chk("t1_busy1", 128'(w_busy1), 128'd1);
    chk("t1_done_cyc", 128'(w_n), 128'd6);
    chk("t1_i_cnt", 128'(w_i_cnt), 128'd1);
    chk("t1_d_cnt", 128'(w_d_cnt), 128'd0);
    chk("t1_no_we", 128'(w_we_cnt), 128'd0);
    chk("t1_rdata", rdata, LINE_100);
    chk("t1_state_done", 128'(state), 128'(ST_DONE));
    step(); i_req = 0;
    chk("t1_idle_busy", 128'(busy), 128'd0);

    // 2: D writeback then D read-back
    d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = WLINE;
    watch();
    chk("t2_we_cnt", 128'(w_we_cnt), 128'd1);
    chk("t2_we_cyc", 128'(w_we_cyc), 128'd5);
    chk("t2_we_addr", 128'(w_we_addr), 128'h2000);
    chk("t2_done_cyc", 128'(w_n), 128'd6);
    chk("t2_d_cnt", 128'(w_d_cnt), 128'd1);
    chk("t2_i_cnt", 128'(w_i_cnt), 128'd0);
    chk("t2_rdata_hold", rdata, LINE_100);
    step(); d_req = 0; d_we = 0;
    d_req = 1; d_addr = 32'h0000_2000;
    watch();
    chk("t2r_done_cyc", 128'(w_n), 128'd6);
    chk("t2r_no_we", 128'(w_we_cnt), 128'd0);
    chk("t2r_rdata", rdata, WLINE);
    step(); d_req = 0;

    // Tie with pointer on I (last grant was a lone D)
    i_req = 1; i_addr = 32'h0000_0104; d_req = 1; d_we = 0; d_addr = 32'h0000_3010;
    watch();
    chk("tie_i_first_i", 128'(w_i_cnt), 128'd1);
    chk("tie_i_first_d", 128'(w_d_cnt), 128'd0);
    chk("tie_i_rdata", rdata, LINE_100);
    step(); i_req = 0;
    chk("tie_gap_busy", 128'(busy), 128'd0);
    watch();
    chk("tie_d_second", 128'(w_d_cnt), 128'd1);
    chk("tie_d_rdata", rdata, LINE_3010);
    step(); d_req = 0;

    // 3: after reset, simultaneous requests: D, I, D, I
    reset = 1; step(); reset = 0;
    for (int pair = 0; pair < 2; pair++) begin
      i_req = 1; i_addr = 32'h0000_0104; d_req = 1; d_we = 0; d_addr = 32'h0000_2000;
      watch();
      chk("t3_first_d", 128'(w_d_cnt), 128'd1);
      chk("t3_first_not_i", 128'(w_i_cnt), 128'd0);
      chk("t3_first_rdata", rdata, WLINE);
      step(); d_req = 0;
      chk("t3_gap_busy", 128'(busy), 128'd0);
      watch();
      chk("t3_regrant_busy", 128'(w_busy1), 128'd1);
      chk("t3_second_i", 128'(w_i_cnt), 128'd1);
      chk("t3_second_cyc", 128'(w_n), 128'd6);
      chk("t3_second_rdata", rdata, LINE_100);
      step(); i_req = 0;
      chk("t3_gap2_busy", 128'(busy), 128'd0);
    end

    // 4: reset on the strobe cycle of a D write
    d_req = 1; d_we = 1; d_addr = 32'h0000_3000; d_wdata = WLINE2;
    for (int k = 0; k < 5; k++) step();
    chk("t4_busy_pre", 128'(state), 128'(ST_BUSY));
    reset = 1; #1;
    chk("t4_we_gated", 128'(mem_we), 128'd0);
    step(); reset = 0; d_req = 0; d_we = 0;
    chk("t4_state_idle", 128'(state), 128'(ST_IDLE));
    chk("t4_no_done", 128'(d_done), 128'd0);
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (d_done || i_done || mem_we) extra_done++;
    end
    chk("t4_quiet", 128'(extra_done), 128'd0);
    d_req = 1; d_addr = 32'h0000_3000;
    watch();
    chk("t4_mem_unchanged", rdata, LINE_3000);
    step(); d_req = 0;

    // 5: MEM_LAT = 1, held request is regranted
    i_req2 = 1; i_addr2 = 32'h0000_0048;
    step();
    chk("t5_busy", 128'(state2), 128'(ST_BUSY));
    chk("t5_addr", 128'(mem_addr2), 128'h40);
    step();
    chk("t5_done1", 128'(i_done2), 128'd1);
    chk("t5_rdata", rdata2, LINE_40);
    step();
    chk("t5_idle", 128'(state2), 128'(ST_IDLE));
    chk("t5_idle_done", 128'(i_done2), 128'd0);
    step();
    chk("t5_regrant", 128'(state2), 128'(ST_BUSY));
    step();
    chk("t5_done2", 128'(i_done2), 128'd1);
    step(); i_req2 = 0;
    d_req2 = 1; d_we2 = 1; d_addr2 = 32'h0000_0050; d_wdata2 = WLINE2;
    step();
    chk("t5_we", 128'(mem_we2), 128'd1);
    chk("t5_we_addr", 128'(mem_addr2), 128'h50);
    step();
    chk("t5_wdone", 128'(d_done2), 128'd1);
    chk("t5_we_off", 128'(mem_we2), 128'd0);
    chk("t5_rdata_hold", rdata2, LINE_40);
    step(); d_req2 = 0; d_we2 = 0;
    step();
    chk("t5_end_idle", 128'(state2), 128'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
